// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks (subtractor today,
// serial adder/multiplier later). State encodings are plain 2-bit constants
// so older blocks that compare against raw values keep working.
package serial_subtractor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Combinational half subtractor: diff = a - b on single bits, borrow set
// when a 0 has to lend to a 1.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b;
    assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// Operands are latched on the accepting edge, the borrow is carried in a
// register between bits, and the result is published with a one-cycle done.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-subtract of the current LSBs: two half subtractors, borrows ORed.
    logic hs0_diff, hs0_borrow;
    logic bit_diff, hs1_borrow;
    logic bit_borrow;

    half_subtractor u_hs0 (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .diff   (hs0_diff),
        .borrow (hs0_borrow)
    );

    half_subtractor u_hs1 (
        .a      (hs0_diff),
        .b      (br_q),
        .diff   (bit_diff),
        .borrow (hs1_borrow)
    );

    assign bit_borrow = hs0_borrow | hs1_borrow;

    // Result register shifted right with the new difference bit entering at the MSB.
    logic [WIDTH-1:0] res_shift;
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = bit_diff;
    end

    // Next-state logic for the FSM, counter, operand and result registers.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = bit_borrow;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Last bit: publish the completed word together with the final borrow.
                    diff_d   = res_shift;
                    borrow_d = bit_borrow;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything, aborting any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: a WIDTH=4 instance exercised with directed
// and random operands, plus a WIDTH=1 instance swept over all operand pairs.
// Expected values come from plain modular arithmetic on the operands.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;

    logic         start1 = 1'b0;
    logic         a1 = 1'b0;
    logic         b1 = 1'b0;
    logic         busy1, done1, diff1, borrow_out1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .a          (a1),
        .b          (b1),
        .busy       (busy1),
        .done       (done1),
        .diff       (diff1),
        .borrow_out (borrow_out1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: modular difference and unsigned less-than.
    function automatic logic [31:0] model_diff(input int x, input int y, input int w);
        return 32'((x - y) & ((1 << w) - 1));
    endfunction

    // One operation on the 4-bit DUT. With hold=1, start stays high and the
    // inputs are switched to 1/1 after acceptance to show they are ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit hold);
        logic [31:0] exp_d;
        logic [31:0] exp_b;
        exp_d = model_diff(int'(ta), int'(tb_v), W);
        exp_b = (ta < tb_v) ? 32'd1 : 32'd0;
        a = ta;
        b = tb_v;
        start = 1'b1;
        tick();
        if (hold) begin
            a = 4'd1;
            b = 4'd1;
        end else begin
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
        end
        for (int i = 0; i < W; i++) begin
            check("busy_shift", 32'(busy), 32'd1);
            check("done_low_shift", 32'(done), 32'd0);
            tick();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("diff", 32'(diff), exp_d);
        check("borrow", 32'(borrow_out), exp_b);
        tick();
        check("done_once", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("diff_hold", 32'(diff), exp_d);
        check("borrow_hold", 32'(borrow_out), exp_b);
    endtask

    // One operation on the 1-bit DUT: exactly one SHIFT cycle.
    task automatic run_op1(input logic ta, input logic tb_v);
        a1 = ta;
        b1 = tb_v;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", 32'(busy1), 32'd1);
        check("w1_done_low", 32'(done1), 32'd0);
        tick();
        check("w1_done", 32'(done1), 32'd1);
        check("w1_diff", 32'(diff1), model_diff(int'(ta), int'(tb_v), 1));
        check("w1_borrow", 32'(borrow_out1), (ta < tb_v) ? 32'd1 : 32'd0);
        tick();
        check("w1_done_once", 32'(done1), 32'd0);
    endtask

    initial begin
        // Reset held two edges with start high: nothing may begin.
        rst = 1'b1;
        start = 1'b1;
        a = 4'd9;
        b = 4'd3;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_w1_busy", 32'(busy1), 32'd0);
        check("rst_w1_diff", 32'(diff1), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Directed operations.
        run_op(4'd9, 4'd3, 1'b0);
        run_op(4'd3, 4'd9, 1'b0);
        run_op(4'd0, 4'd1, 1'b0);
        run_op(4'd15, 4'd15, 1'b0);

        // start held through SHIFT and DONE with different operands.
        run_op(4'd12, 4'd5, 1'b1);
        run_op(4'd1, 4'd1, 1'b0);
        tick();

        // Reset in the second SHIFT cycle aborts the operation.
        a = 4'd14;
        b = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(4'd7, 4'd2, 1'b0);

        // Random operands.
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'b0);
        end

        // Exhaustive sweep of the 4-bit instance.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(W'(x), W'(y), 1'b0);
            end
        end

        // Exhaustive sweep of the 1-bit instance.
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                run_op1(1'(x), 1'(y));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
